trace_monitor: RTL and testbench

Synthesizable, parametrised execution-trace capture unit for the pipelined RISC-V CPU. It replaces per-cycle bench printing and the fixed 64-cycle stop with a hardware run controller. It samples register-file writebacks and data-memory writes on a configurable cycle window and buffers them in a dual-push FIFO. The FIFO drains over a valid/ready stream. It sits beside the CPU and is fed from the WB-stage register write port and the MEM-stage data-memory write port.

---
 rtl/trace_monitor.sv | 142 ++++++++++++++
 tb/tb_trace_monitor.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/trace_monitor.sv
// trace_monitor: cycle-windowed capture of register writebacks and data-memory
// writes from the CPU into a dual-push FIFO drained over a valid/ready stream.
module trace_monitor #(
    parameter int XLEN       = 32,
    parameter int DEPTH      = 16,
    parameter int MAX_CYCLES = 64,
    parameter int CNT_W      = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic [XLEN-1:0]          pc_i,
    input  logic                     wb_en_i,
    input  logic [4:0]               wb_addr_i,
    input  logic [XLEN-1:0]          wb_data_i,
    input  logic                     mem_wr_en_i,
    input  logic [XLEN-1:0]          mem_addr_i,
    input  logic [XLEN-1:0]          mem_data_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [1:0]               out_kind_o,
    output logic [CNT_W-1:0]         out_cycle_o,
    output logic [XLEN-1:0]          out_pc_o,
    output logic [XLEN-1:0]          out_addr_o,
    output logic [XLEN-1:0]          out_data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     halt_o,
    output logic                     overflow_o,
    output logic [CNT_W-1:0]         drop_cnt_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = 2 + CNT_W + 3 * XLEN;
    localparam logic [CNT_W-1:0] LAST_CYC = CNT_W'(MAX_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cyc_reg;
    logic [AW-1:0]     wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]     count_reg;
    logic [CNT_W-1:0]  drop_cnt_reg;
    logic              overflow_reg;
    logic [EW-1:0]     fifo_mem [DEPTH];

    logic              run;
    logic              reg_ev, mem_ev;
    logic              push_reg, push_mem, pop;
    logic [CW-1:0]     free_slots;
    logic [1:0]        n_push, n_drop;
    logic [AW-1:0]     mem_slot;
    logic [EW-1:0]     reg_entry, mem_entry, head_entry;
    logic [CNT_W:0]    drop_sum;

    // State register for the IDLE/RUN/HALT run controller
    always_ff @(posedge clk_i) begin
        if (rst_i) state_reg <= S_IDLE;
        else       state_reg <= state_next;
    end

    // Next-state: arm on start, stop after the last window cycle, HALT is terminal
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (start_i) state_next = S_RUN;
            S_RUN:   if (cyc_reg == LAST_CYC) state_next = S_HALT;
            S_HALT:  state_next = S_HALT;
            default: state_next = S_IDLE;
        endcase
    end

    // Run-cycle index: cleared on arming, advances through the window
    always_ff @(posedge clk_i) begin
        if (rst_i)                                 cyc_reg <= '0;
        else if (state_reg == S_IDLE && start_i)   cyc_reg <= '0;
        else if (state_reg == S_RUN && cyc_reg != LAST_CYC) cyc_reg <= cyc_reg + 1'b1;
    end

    assign run    = (state_reg == S_RUN);
    assign reg_ev = run && wb_en_i && (wb_addr_i != 5'd0);
    assign mem_ev = run && mem_wr_en_i;

    // Space is judged against start-of-cycle occupancy; a same-cycle pop never helps
    assign free_slots = CW'(DEPTH) - count_reg;
    assign push_reg   = reg_ev && (free_slots != '0);
    assign push_mem   = mem_ev && (reg_ev ? (free_slots >= CW'(2)) : (free_slots != '0));
    assign n_push     = {1'b0, push_reg} + {1'b0, push_mem};
    assign n_drop     = {1'b0, reg_ev && !push_reg} + {1'b0, mem_ev && !push_mem};
    assign pop        = (count_reg != '0) && out_ready_i;

    // Register event always takes the lower slot so it drains first
    assign mem_slot  = wr_ptr_reg + AW'(push_reg);
    assign reg_entry = {2'b01, cyc_reg, pc_i, {{(XLEN-5){1'b0}}, wb_addr_i}, wb_data_i};
    assign mem_entry = {2'b10, cyc_reg, pc_i, mem_addr_i, mem_data_i};

    // Entry storage: up to two writes per cycle to distinct slots
    always_ff @(posedge clk_i) begin
        if (push_reg) fifo_mem[wr_ptr_reg] <= reg_entry;
        if (push_mem) fifo_mem[mem_slot]   <= mem_entry;
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_reg + AW'(n_push);
            if (pop) rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg  <= count_reg + CW'(n_push) - CW'(pop);
        end
    end

    assign drop_sum = {1'b0, drop_cnt_reg} + (CNT_W+1)'(n_drop);

    // Saturating drop counter and sticky overflow flag
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            drop_cnt_reg <= '0;
            overflow_reg <= 1'b0;
        end else begin
            drop_cnt_reg <= drop_sum[CNT_W] ? {CNT_W{1'b1}} : drop_sum[CNT_W-1:0];
            if (n_drop != 2'd0) overflow_reg <= 1'b1;
        end
    end

    // Payload is forced to zero while empty so stale slots never leak out
    assign head_entry  = (count_reg != '0) ? fifo_mem[rd_ptr_reg] : '0;
    assign out_valid_o = (count_reg != '0);
    assign out_kind_o  = head_entry[EW-1 -: 2];
    assign out_cycle_o = head_entry[EW-3 -: CNT_W];
    assign out_pc_o    = head_entry[3*XLEN-1 -: XLEN];
    assign out_addr_o  = head_entry[2*XLEN-1 -: XLEN];
    assign out_data_o  = head_entry[XLEN-1:0];
    assign count_o     = count_reg;
    assign halt_o      = (state_reg == S_HALT);
    assign overflow_o  = overflow_reg;
    assign drop_cnt_o  = drop_cnt_reg;

endmodule

// File: tb/tb_trace_monitor.sv
// Scoreboard bench for trace_monitor (DEPTH=4, MAX_CYCLES=8).
module tb_trace_monitor;

    typedef struct packed {
        logic [1:0]  kind;
        logic [15:0] cyc;
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
    } ent_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] pc;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        mem_wr_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_kind;
    logic [15:0] out_cycle;
    logic [31:0] out_pc;
    logic [31:0] out_addr;
    logic [31:0] out_data;
    logic [2:0]  count;
    logic        halt;
    logic        overflow;
    logic [15:0] drop_cnt;

    ent_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   pops = 0;

    trace_monitor #(.XLEN(32), .DEPTH(4), .MAX_CYCLES(8), .CNT_W(16)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .pc_i(pc),
        .wb_en_i(wb_en), .wb_addr_i(wb_addr), .wb_data_i(wb_data),
        .mem_wr_en_i(mem_wr_en), .mem_addr_i(mem_addr), .mem_data_i(mem_data),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_kind_o(out_kind),
        .out_cycle_o(out_cycle), .out_pc_o(out_pc), .out_addr_o(out_addr),
        .out_data_o(out_data), .count_o(count), .halt_o(halt),
        .overflow_o(overflow), .drop_cnt_o(drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: consume one expected entry per accepted handshake
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            ent_t got;
            got = '{out_kind, out_cycle, out_pc, out_addr, out_data};
            pops++;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_pop: got kind=%0d data=%0h expected no entry", out_kind, out_data);
            end else begin
                ent_t e;
                e = exp_q.pop_front();
                $display("pop kind=%0d cyc=%0d pc=%0h addr=%0h data=%0h", got.kind, got.cyc, got.pc, got.addr, got.data);
                if (got !== e) begin
                    miscompares++;
                    $display("FAIL entry: got kind=%0d cyc=%0d pc=%0h addr=%0h data=%0h expected kind=%0d cyc=%0d pc=%0h addr=%0h data=%0h",
                             got.kind, got.cyc, got.pc, got.addr, got.data, e.kind, e.cyc, e.pc, e.addr, e.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_events();
        wb_en = 0; wb_addr = 0; wb_data = 0;
        mem_wr_en = 0; mem_addr = 0; mem_data = 0; pc = 0;
    endtask

    task automatic ev(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                      input logic me, input logic [31:0] ma, input logic [31:0] md,
                      input logic [31:0] p);
        wb_en = we; wb_addr = wa; wb_data = wd;
        mem_wr_en = me; mem_addr = ma; mem_data = md; pc = p;
        tick();
        clear_events();
    endtask

    task automatic do_reset();
        rst = 1; start = 0; out_ready = 0;
        clear_events();
        tick();
        rst = 0;
        exp_q.delete();
    endtask

    task automatic start_run();
        start = 1;
        tick();
        start = 0;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 20 && (exp_q.size() != 0 || out_valid); i++) tick();
        check(name, exp_q.size(), 0);
    endtask

    logic       rdy_seq [5];
    logic [31:0] head_seq [5];
    int          pops_before;

    initial begin
        rst = 1; start = 0; out_ready = 0;
        clear_events();
        tick(); tick();
        // Reset state
        check("rst_valid", out_valid, 0);
        check("rst_count", count, 0);
        check("rst_halt", halt, 0);
        check("rst_overflow", overflow, 0);
        check("rst_drop", drop_cnt, 0);
        check("rst_data", out_data, 0);
        rst = 0;

        // Basic capture in run cycle 2, halt after cycle 7
        out_ready = 1;
        start_run();
        tick(); tick();
        exp_q.push_back('{2'b01, 16'd2, 32'h8, 32'd5, 32'h2A});
        ev(1, 5'd5, 32'h2A, 0, 0, 0, 32'h8);
        check("t1_count", count, 1);
        check("t1_valid", out_valid, 1);
        for (int i = 0; i < 4; i++) tick();
        check("t1_halt_before", halt, 0);
        tick();
        check("t1_halt_rise", halt, 1);
        tick(); tick();
        start = 1; tick(); start = 0;
        check("t1_halt_stays", halt, 1);
        wait_drain("t1_drain");

        // x0 filter and dual push
        do_reset();
        out_ready = 1;
        start_run();
        ev(1, 5'd0, 32'h55, 0, 0, 0, 32'h4);
        check("t2_x0_count", count, 0);
        check("t2_x0_valid", out_valid, 0);
        exp_q.push_back('{2'b01, 16'd1, 32'hC, 32'd3, 32'd7});
        exp_q.push_back('{2'b10, 16'd1, 32'hC, 32'h10, 32'd9});
        ev(1, 5'd3, 32'd7, 1, 32'h10, 32'd9, 32'hC);
        check("t2_count", count, 2);
        wait_drain("t2_drain");

        // Overflow: three dual cycles into a 4-deep FIFO
        do_reset();
        start_run();
        for (int c = 0; c < 3; c++) begin
            if (c < 2) begin
                exp_q.push_back('{2'b01, 16'(c), 32'(4*c), 32'(c+1), 32'(32'h100 + c)});
                exp_q.push_back('{2'b10, 16'(c), 32'(4*c), 32'(32'h200 + 4*c), 32'(32'h300 + c)});
            end
            ev(1, 5'(c+1), 32'h100 + 32'(c), 1, 32'h200 + 32'(4*c), 32'h300 + 32'(c), 32'(4*c));
        end
        check("t3_count", count, 4);
        check("t3_drop", drop_cnt, 2);
        check("t3_overflow", overflow, 1);
        check("t3_head", out_data, 32'h100);

        // Full with simultaneous pop: the event is still dropped
        out_ready = 1;
        ev(1, 5'd7, 32'h77, 0, 0, 0, 32'h30);
        check("t4_count", count, 3);
        check("t4_drop", drop_cnt, 3);
        check("t4_overflow", overflow, 1);
        wait_drain("t4_drain");

        // Reset mid-run
        do_reset();
        start_run();
        ev(1, 5'd1, 32'h11, 1, 32'h20, 32'h22, 32'h0);
        ev(1, 5'd2, 32'h33, 0, 0, 0, 32'h4);
        check("t5_count_pre", count, 3);
        rst = 1;
        tick();
        rst = 0;
        exp_q.delete();
        check("t5_count", count, 0);
        check("t5_valid", out_valid, 0);
        check("t5_halt", halt, 0);
        check("t5_drop", drop_cnt, 0);
        check("t5_overflow", overflow, 0);

        // Restart at cycle 0, then backpressure stability
        start_run();
        exp_q.push_back('{2'b01, 16'd0, 32'h40, 32'd9, 32'h99});
        exp_q.push_back('{2'b01, 16'd1, 32'h44, 32'd10, 32'hAA});
        ev(1, 5'd9, 32'h99, 0, 0, 0, 32'h40);
        ev(1, 5'd10, 32'hAA, 0, 0, 0, 32'h44);
        check("t6_count", count, 2);
        rdy_seq  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        head_seq = '{32'h99, 32'h99, 32'h99, 32'hAA, 32'hAA};
        pops_before = pops;
        for (int i = 0; i < 5; i++) begin
            out_ready = rdy_seq[i];
            check("t6_head", out_data, head_seq[i]);
            tick();
        end
        check("t6_pops", pops - pops_before, 2);
        check("t6_count_end", count, 0);
        check("t6_valid_end", out_valid, 0);
        check("final_queue", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
